// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the N-port data-memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_FIXED       = 1'b0,
        ARB_ROUND_ROBIN = 1'b1
    } arb_mode_e;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    localparam int BYTES_PER_WORD = 4;

    // Width of a port index; a lone port still needs one bit.
    function automatic int port_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/data_mem_multi_arbiter_if.sv
// Requester and memory-port bundle of the data-memory arbiter.
interface data_mem_multi_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int XLEN      = 32
);

    logic [NUM_PORTS-1:0]                i_req_valid;
    logic [NUM_PORTS-1:0]                i_req_we;
    logic [NUM_PORTS-1:0]                i_req_lock;
    logic [NUM_PORTS*XLEN-1:0]           i_req_addr;
    logic [NUM_PORTS*XLEN-1:0]           i_req_wdata;
    logic [NUM_PORTS*BYTES_PER_WORD-1:0] i_req_be;
    logic [NUM_PORTS-1:0]                o_req_ready;

    logic [XLEN-1:0]                     o_mem_addr;
    logic [XLEN-1:0]                     o_mem_wr_data;
    logic [BYTES_PER_WORD-1:0]           o_mem_per_byte_wr_en;
    logic                                o_mem_read_enable;
    logic                                i_mem_ready;
    logic                                i_mem_rsp_valid;
    logic [XLEN-1:0]                     i_mem_rsp_data;

    logic [NUM_PORTS-1:0]                o_rsp_valid;
    logic [XLEN-1:0]                     o_rsp_data;

    modport slave (
        input  i_req_valid, i_req_we, i_req_lock, i_req_addr, i_req_wdata, i_req_be,
        output o_req_ready,
        output o_mem_addr, o_mem_wr_data, o_mem_per_byte_wr_en, o_mem_read_enable,
        input  i_mem_ready, i_mem_rsp_valid, i_mem_rsp_data,
        output o_rsp_valid, o_rsp_data
    );

    modport master (
        output i_req_valid, i_req_we, i_req_lock, i_req_addr, i_req_wdata, i_req_be,
        input  o_req_ready,
        input  o_mem_addr, o_mem_wr_data, o_mem_per_byte_wr_en, o_mem_read_enable,
        output i_mem_ready, i_mem_rsp_valid, i_mem_rsp_data,
        input  o_rsp_valid, o_rsp_data
    );

endinterface

// File: rtl/mem_arb_rsp_tracker.sv
// In-order FIFO of issuing port indices; routes each read response back to its requester.
module mem_arb_rsp_tracker
    import mem_arb_pkg::*;
#(
    parameter int  NUM_PORTS       = 4,
    parameter int  MAX_OUTSTANDING = 2,
    localparam int IW              = port_idx_width(NUM_PORTS)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_push,
    input  logic [IW-1:0]        i_push_idx,
    input  logic                 i_rsp_valid,
    output logic                 o_full,
    output logic [NUM_PORTS-1:0] o_rsp_onehot,
    output logic                 o_rsp_orphan
);

    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [IW-1:0] slots_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          orphan_q, orphan_d;
    logic          empty;
    logic          pop;
    logic [IW-1:0] head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_full       = (count_q == CW'(MAX_OUTSTANDING));
    assign empty        = (count_q == '0);
    assign pop          = i_rsp_valid && !empty;
    assign head         = slots_q[rd_ptr_q];
    assign o_rsp_onehot = pop ? (NUM_PORTS'(1) << head) : '0;
    assign o_rsp_orphan = orphan_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        orphan_d = orphan_q || (i_rsp_valid && empty);
        if (i_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)    rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({i_push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            orphan_q <= orphan_d;
        end
    end

    // NOTE: slot storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge i_clk) begin
        if (i_push) slots_q[wr_ptr_q] <= i_push_idx;
    end

endmodule

// File: rtl/data_mem_multi_arbiter.sv
// N-port valid/ready arbiter onto one data-memory port with lock hold and read-response routing.
module data_mem_multi_arbiter
    import mem_arb_pkg::*;
#(
    parameter int        NUM_PORTS       = 4,
    parameter int        XLEN            = 32,
    parameter arb_mode_e ARB_MODE        = ARB_FIXED,
    parameter int        MAX_OUTSTANDING = 2,
    localparam int       IW              = port_idx_width(NUM_PORTS)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    data_mem_multi_arbiter_if.slave   bus,
    output logic [IW-1:0]             o_grant_idx,
    output logic                      o_locked,
    output logic                      o_rsp_orphan
);

    localparam logic [0:0] ST_UNLOCKED = UNLOCKED;
    localparam logic [0:0] ST_LOCKED   = LOCKED;

    logic [0:0]                state_q, state_d;
    logic [IW-1:0]             lock_owner_q, lock_owner_d;
    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]             grant_idx_q;
    logic [IW-1:0]             grant_idx;
    logic                      g_valid, g_we, g_lock;
    logic [BYTES_PER_WORD-1:0] g_be;
    logic                      trk_full;
    logic                      eligible;
    logic                      issue;
    int                        cand;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        grant_idx = grant_idx_q;
        cand      = 0;
        if (state_q == ST_LOCKED) begin
            grant_idx = lock_owner_q;
        end else if (ARB_MODE == ARB_FIXED) begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (bus.i_req_valid[i]) grant_idx = IW'(i);
            end
        end else begin
            // Scan backwards so the nearest valid port at or after rr_ptr wins.
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
                if (bus.i_req_valid[cand]) grant_idx = IW'(cand);
            end
        end
    end

    assign g_valid = bus.i_req_valid[grant_idx];
    assign g_we    = bus.i_req_we[grant_idx];
    assign g_lock  = bus.i_req_lock[grant_idx];
    assign g_be    = bus.i_req_be[int'(grant_idx)*BYTES_PER_WORD +: BYTES_PER_WORD];

    // Registered full only: a same-cycle response never frees a read slot.
    assign eligible = g_we || !trk_full;
    assign issue    = g_valid && eligible && bus.i_mem_ready;

    assign bus.o_req_ready          = (eligible && bus.i_mem_ready) ? (NUM_PORTS'(1) << grant_idx) : '0;
    assign bus.o_mem_addr           = bus.i_req_addr[int'(grant_idx)*XLEN +: XLEN];
    assign bus.o_mem_wr_data        = bus.i_req_wdata[int'(grant_idx)*XLEN +: XLEN];
    assign bus.o_mem_per_byte_wr_en = (issue && g_we) ? g_be : '0;
    assign bus.o_mem_read_enable    = issue && !g_we;
    assign bus.o_rsp_data           = bus.i_mem_rsp_data;

    assign o_grant_idx = grant_idx;
    assign o_locked    = (state_q == ST_LOCKED);

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        state_d      = state_q;
        lock_owner_d = lock_owner_q;
        if (issue && state_q == ST_UNLOCKED) begin
            rr_ptr_d = (grant_idx == IW'(NUM_PORTS - 1)) ? '0 : grant_idx + IW'(1);
        end
        case (state_q)
            ST_UNLOCKED: begin
                if (issue && g_lock) begin
                    state_d      = ST_LOCKED;
                    lock_owner_d = grant_idx;
                end
            end
            default: begin
                if (issue && !g_lock) state_d = ST_UNLOCKED;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_UNLOCKED;
            lock_owner_q <= '0;
            rr_ptr_q     <= '0;
            grant_idx_q  <= '0;
        end else begin
            state_q      <= state_d;
            lock_owner_q <= lock_owner_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_idx_q  <= grant_idx;
        end
    end

    mem_arb_rsp_tracker #(
        .NUM_PORTS       (NUM_PORTS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_rsp_tracker (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_push       (issue && !g_we),
        .i_push_idx   (grant_idx),
        .i_rsp_valid  (bus.i_mem_rsp_valid),
        .o_full       (trk_full),
        .o_rsp_onehot (bus.o_rsp_valid),
        .o_rsp_orphan (o_rsp_orphan)
    );

endmodule

// File: tb/tb_data_mem_multi_arbiter.sv
// Directed bench: a fixed-priority and a round-robin arbiter instance, four ports, two outstanding reads.
module tb_data_mem_multi_arbiter;
    import mem_arb_pkg::*;

    localparam int NP = 4;
    localparam int XL = 32;
    localparam int MO = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_multi_arbiter_if #(.NUM_PORTS(NP), .XLEN(XL)) fx ();
    data_mem_multi_arbiter_if #(.NUM_PORTS(NP), .XLEN(XL)) rr ();

    logic [1:0] fx_grant, rr_grant;
    logic       fx_locked, rr_locked, fx_orphan, rr_orphan;

    data_mem_multi_arbiter #(
        .NUM_PORTS(NP), .XLEN(XL), .ARB_MODE(ARB_FIXED), .MAX_OUTSTANDING(MO)
    ) u_fix (
        .i_clk(clk), .i_rst(rst), .bus(fx),
        .o_grant_idx(fx_grant), .o_locked(fx_locked), .o_rsp_orphan(fx_orphan)
    );

    data_mem_multi_arbiter #(
        .NUM_PORTS(NP), .XLEN(XL), .ARB_MODE(ARB_ROUND_ROBIN), .MAX_OUTSTANDING(MO)
    ) u_rr (
        .i_clk(clk), .i_rst(rst), .bus(rr),
        .o_grant_idx(rr_grant), .o_locked(rr_locked), .o_rsp_orphan(rr_orphan)
    );

    task automatic clear_inputs();
        fx.i_req_valid = '0; fx.i_req_we = '0; fx.i_req_lock = '0;
        fx.i_req_addr = '0; fx.i_req_wdata = '0; fx.i_req_be = '0;
        fx.i_mem_ready = 1'b0; fx.i_mem_rsp_valid = 1'b0; fx.i_mem_rsp_data = '0;
        rr.i_req_valid = '0; rr.i_req_we = '0; rr.i_req_lock = '0;
        rr.i_req_addr = '0; rr.i_req_wdata = '0; rr.i_req_be = '0;
        rr.i_mem_ready = 1'b0; rr.i_mem_rsp_valid = 1'b0; rr.i_mem_rsp_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #2;
        checks++; if (fx.o_req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready got=%b exp=0000", fx.o_req_ready); end
        checks++; if (fx.o_mem_per_byte_wr_en !== 4'b0000) begin errors++; $display("FAIL rst_wr_en got=%b exp=0000", fx.o_mem_per_byte_wr_en); end
        checks++; if (fx.o_mem_read_enable !== 1'b0) begin errors++; $display("FAIL rst_read_en got=%b exp=0", fx.o_mem_read_enable); end
        checks++; if (fx.o_rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_rsp_valid got=%b exp=0000", fx.o_rsp_valid); end
        checks++; if (fx_grant !== 2'd0 || rr_grant !== 2'd0) begin errors++; $display("FAIL rst_grant got=%0d/%0d exp=0/0", fx_grant, rr_grant); end
        checks++; if (fx_locked !== 1'b0 || rr_locked !== 1'b0) begin errors++; $display("FAIL rst_locked got=%b/%b exp=0/0", fx_locked, rr_locked); end
        checks++; if (fx_orphan !== 1'b0 || rr_orphan !== 1'b0) begin errors++; $display("FAIL rst_orphan got=%b/%b exp=0/0", fx_orphan, rr_orphan); end
        @(negedge clk);
        rst = 1'b0;
        fx.i_mem_ready = 1'b1;
        rr.i_mem_ready = 1'b1;
    endtask

    task automatic test_fixed_priority();
        @(negedge clk);
        fx.i_req_valid = 4'b1010; fx.i_req_we = 4'b0000;
        fx.i_req_addr  = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100, 32'h0000_0000};
        #1;
        checks++; if (fx_grant !== 2'd1) begin errors++; $display("FAIL fix_grant_p1 got=%0d exp=1", fx_grant); end
        checks++; if (fx.o_req_ready !== 4'b0010) begin errors++; $display("FAIL fix_ready_p1 got=%b exp=0010", fx.o_req_ready); end
        checks++; if (fx.o_mem_read_enable !== 1'b1) begin errors++; $display("FAIL fix_read_en_p1 got=%b exp=1", fx.o_mem_read_enable); end
        checks++; if (fx.o_mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL fix_addr_p1 got=%h exp=00000100", fx.o_mem_addr); end
        checks++; if (fx.o_mem_per_byte_wr_en !== 4'b0000) begin errors++; $display("FAIL fix_wr_en_rd got=%b exp=0000", fx.o_mem_per_byte_wr_en); end
        @(negedge clk);
        fx.i_req_valid = 4'b1000;
        #1;
        checks++; if (fx_grant !== 2'd3) begin errors++; $display("FAIL fix_grant_p3 got=%0d exp=3", fx_grant); end
        checks++; if (fx.o_req_ready !== 4'b1000) begin errors++; $display("FAIL fix_ready_p3 got=%b exp=1000", fx.o_req_ready); end
        checks++; if (fx.o_mem_addr !== 32'h0000_0300) begin errors++; $display("FAIL fix_addr_p3 got=%h exp=00000300", fx.o_mem_addr); end
        @(negedge clk);
        fx.i_req_valid = 4'b0000; fx.i_mem_rsp_valid = 1'b1; fx.i_mem_rsp_data = 32'h1111_0001;
        #1;
        checks++; if (fx.o_rsp_valid !== 4'b0010) begin errors++; $display("FAIL fix_rsp_route_p1 got=%b exp=0010", fx.o_rsp_valid); end
        checks++; if (fx.o_rsp_data !== 32'h1111_0001) begin errors++; $display("FAIL fix_rsp_data_p1 got=%h exp=11110001", fx.o_rsp_data); end
        @(negedge clk);
        fx.i_mem_rsp_data = 32'h3333_0003;
        #1;
        checks++; if (fx.o_rsp_valid !== 4'b1000) begin errors++; $display("FAIL fix_rsp_route_p3 got=%b exp=1000", fx.o_rsp_valid); end
        @(negedge clk);
        fx.i_mem_rsp_valid = 1'b0;
        #1;
        checks++; if (fx.o_rsp_valid !== 4'b0000) begin errors++; $display("FAIL fix_rsp_idle got=%b exp=0000", fx.o_rsp_valid); end
        checks++; if (fx_grant !== 2'd3) begin errors++; $display("FAIL fix_grant_hold got=%0d exp=3", fx_grant); end
    endtask

    task automatic test_round_robin();
        int          exp_g [5] = '{0, 1, 2, 3, 0};
        logic [15:0] be_all = {4'h1, 4'hC, 4'h3, 4'hF};
        logic [3:0]  exp_rdy;
        logic [3:0]  exp_be;
        @(negedge clk);
        rr.i_req_valid = 4'b1111; rr.i_req_we = 4'b1111; rr.i_req_be = be_all;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            exp_rdy = 4'b0001 << exp_g[i];
            exp_be  = be_all[exp_g[i]*4 +: 4];
            checks++; if (rr_grant !== 2'(exp_g[i])) begin errors++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, rr_grant, exp_g[i]); end
            checks++; if (rr.o_req_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, rr.o_req_ready, exp_rdy); end
            checks++; if (rr.o_mem_per_byte_wr_en !== exp_be) begin errors++; $display("FAIL rr_be[%0d] got=%b exp=%b", i, rr.o_mem_per_byte_wr_en, exp_be); end
            checks++; if (rr.o_mem_read_enable !== 1'b0) begin errors++; $display("FAIL rr_read_en[%0d] got=%b exp=0", i, rr.o_mem_read_enable); end
        end
        @(negedge clk);
        rr.i_req_valid = '0; rr.i_req_we = '0; rr.i_req_be = '0;
    endtask

    task automatic test_lock();
        @(negedge clk);
        fx.i_req_valid = 4'b0100; fx.i_req_we = 4'b0000; fx.i_req_lock = 4'b0100;
        #1;
        checks++; if (fx.o_req_ready !== 4'b0100) begin errors++; $display("FAIL lock_acq_ready got=%b exp=0100", fx.o_req_ready); end
        checks++; if (fx_locked !== 1'b0) begin errors++; $display("FAIL lock_pre got=%b exp=0", fx_locked); end
        @(negedge clk);
        fx.i_req_valid = 4'b0001; fx.i_req_lock = 4'b0000;
        #1;
        checks++; if (fx_locked !== 1'b1) begin errors++; $display("FAIL lock_held got=%b exp=1", fx_locked); end
        checks++; if (fx.o_req_ready !== 4'b0100) begin errors++; $display("FAIL lock_block_p0 got=%b exp=0100", fx.o_req_ready); end
        checks++; if (fx_grant !== 2'd2) begin errors++; $display("FAIL lock_grant_owner got=%0d exp=2", fx_grant); end
        checks++; if (fx.o_mem_read_enable !== 1'b0) begin errors++; $display("FAIL lock_no_issue got=%b exp=0", fx.o_mem_read_enable); end
        @(negedge clk);
        fx.i_req_valid = 4'b0101; fx.i_req_we = 4'b0100; fx.i_req_be = 16'h0A00;
        #1;
        checks++; if (fx.o_req_ready !== 4'b0100) begin errors++; $display("FAIL lock_rel_ready got=%b exp=0100", fx.o_req_ready); end
        checks++; if (fx.o_mem_per_byte_wr_en !== 4'hA) begin errors++; $display("FAIL lock_rel_be got=%h exp=a", fx.o_mem_per_byte_wr_en); end
        checks++; if (fx_locked !== 1'b1) begin errors++; $display("FAIL lock_rel_pre got=%b exp=1", fx_locked); end
        @(negedge clk);
        fx.i_req_valid = 4'b0001; fx.i_req_we = 4'b0000; fx.i_req_be = '0;
        #1;
        checks++; if (fx_locked !== 1'b0) begin errors++; $display("FAIL lock_released got=%b exp=0", fx_locked); end
        checks++; if (fx.o_req_ready !== 4'b0001) begin errors++; $display("FAIL lock_p0_ready got=%b exp=0001", fx.o_req_ready); end
        checks++; if (fx.o_mem_read_enable !== 1'b1) begin errors++; $display("FAIL lock_p0_read got=%b exp=1", fx.o_mem_read_enable); end
        @(negedge clk);
        fx.i_req_valid = '0; fx.i_mem_rsp_valid = 1'b1; fx.i_mem_rsp_data = 32'h2222_0002;
        #1;
        checks++; if (fx.o_rsp_valid !== 4'b0100) begin errors++; $display("FAIL lock_rsp_p2 got=%b exp=0100", fx.o_rsp_valid); end
        @(negedge clk);
        #1;
        checks++; if (fx.o_rsp_valid !== 4'b0001) begin errors++; $display("FAIL lock_rsp_p0 got=%b exp=0001", fx.o_rsp_valid); end
        @(negedge clk);
        fx.i_mem_rsp_valid = 1'b0;
    endtask

    task automatic test_tracker_full();
        @(negedge clk);
        fx.i_req_valid = 4'b0001; fx.i_req_we = '0;
        #1;
        checks++; if (fx.o_mem_read_enable !== 1'b1) begin errors++; $display("FAIL trk_rd0 got=%b exp=1", fx.o_mem_read_enable); end
        @(negedge clk);
        fx.i_req_valid = 4'b0010;
        #1;
        checks++; if (fx.o_req_ready !== 4'b0010) begin errors++; $display("FAIL trk_rd1_ready got=%b exp=0010", fx.o_req_ready); end
        @(negedge clk);
        fx.i_req_valid = 4'b0001; fx.i_mem_rsp_valid = 1'b1; fx.i_mem_rsp_data = 32'hDEAD_BEEF;
        #1;
        checks++; if (fx.o_req_ready !== 4'b0000) begin errors++; $display("FAIL trk_full_ready got=%b exp=0000", fx.o_req_ready); end
        checks++; if (fx.o_mem_read_enable !== 1'b0) begin errors++; $display("FAIL trk_full_read got=%b exp=0", fx.o_mem_read_enable); end
        checks++; if (fx.o_rsp_valid !== 4'b0001) begin errors++; $display("FAIL trk_rsp_valid got=%b exp=0001", fx.o_rsp_valid); end
        checks++; if (fx.o_rsp_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL trk_rsp_data got=%h exp=deadbeef", fx.o_rsp_data); end
        @(negedge clk);
        fx.i_mem_rsp_valid = 1'b0;
        #1;
        checks++; if (fx.o_req_ready !== 4'b0001) begin errors++; $display("FAIL trk_third_ready got=%b exp=0001", fx.o_req_ready); end
        checks++; if (fx.o_mem_read_enable !== 1'b1) begin errors++; $display("FAIL trk_third_read got=%b exp=1", fx.o_mem_read_enable); end
        @(negedge clk);
        fx.i_req_valid = '0; fx.i_mem_rsp_valid = 1'b1; fx.i_mem_rsp_data = 32'h0000_0011;
        #1;
        checks++; if (fx.o_rsp_valid !== 4'b0010) begin errors++; $display("FAIL trk_rsp_p1 got=%b exp=0010", fx.o_rsp_valid); end
        @(negedge clk);
        fx.i_mem_rsp_valid = 1'b0;
    endtask

    task automatic test_mem_not_ready_and_orphan();
        fx.i_req_valid = 4'b0001; fx.i_req_we = 4'b0000; fx.i_mem_ready = 1'b0;
        #1;
        checks++; if (fx.o_req_ready !== 4'b0000) begin errors++; $display("FAIL nrdy_rd_ready got=%b exp=0000", fx.o_req_ready); end
        checks++; if (fx.o_mem_read_enable !== 1'b0) begin errors++; $display("FAIL nrdy_rd_en got=%b exp=0", fx.o_mem_read_enable); end
        @(negedge clk);
        fx.i_req_we = 4'b0001; fx.i_req_be = 16'h000F;
        #1;
        checks++; if (fx.o_req_ready !== 4'b0000) begin errors++; $display("FAIL nrdy_wr_ready got=%b exp=0000", fx.o_req_ready); end
        checks++; if (fx.o_mem_per_byte_wr_en !== 4'b0000) begin errors++; $display("FAIL nrdy_wr_en got=%b exp=0000", fx.o_mem_per_byte_wr_en); end
        @(negedge clk);
        fx.i_req_valid = '0; fx.i_req_we = '0; fx.i_req_be = '0; fx.i_mem_ready = 1'b1;
        fx.i_mem_rsp_valid = 1'b1; fx.i_mem_rsp_data = 32'hCAFE_0001;
        #1;
        checks++; if (fx.o_rsp_valid !== 4'b0001) begin errors++; $display("FAIL nrdy_last_rsp got=%b exp=0001", fx.o_rsp_valid); end
        @(negedge clk);
        fx.i_mem_rsp_data = 32'hCAFE_0002;
        #1;
        checks++; if (fx.o_rsp_valid !== 4'b0000) begin errors++; $display("FAIL orphan_no_strobe got=%b exp=0000", fx.o_rsp_valid); end
        checks++; if (fx_orphan !== 1'b0) begin errors++; $display("FAIL orphan_pre got=%b exp=0", fx_orphan); end
        @(negedge clk);
        fx.i_mem_rsp_valid = 1'b0;
        #1;
        checks++; if (fx_orphan !== 1'b1) begin errors++; $display("FAIL orphan_set got=%b exp=1", fx_orphan); end
        @(negedge clk);
        #1;
        checks++; if (fx_orphan !== 1'b1) begin errors++; $display("FAIL orphan_sticky got=%b exp=1", fx_orphan); end
    endtask

    task automatic test_reset_mid_lock();
        @(negedge clk);
        fx.i_req_valid = 4'b0001; fx.i_req_we = 4'b0001; fx.i_req_lock = 4'b0001; fx.i_req_be = 16'h000F;
        @(negedge clk);
        fx.i_req_we = 4'b0000;
        @(negedge clk);
        fx.i_req_valid = '0; fx.i_req_lock = '0; fx.i_req_be = '0;
        rr.i_req_valid = 4'b1001; rr.i_mem_ready = 1'b0;
        #1;
        checks++; if (fx_locked !== 1'b1) begin errors++; $display("FAIL rml_locked got=%b exp=1", fx_locked); end
        checks++; if (rr_grant !== 2'd3) begin errors++; $display("FAIL rml_rr_ptr1 got=%0d exp=3", rr_grant); end
        rst = 1'b1;
        #1;
        checks++; if (fx_locked !== 1'b0) begin errors++; $display("FAIL rml_unlocked got=%b exp=0", fx_locked); end
        checks++; if (fx_orphan !== 1'b0) begin errors++; $display("FAIL rml_orphan_clr got=%b exp=0", fx_orphan); end
        checks++; if (rr_grant !== 2'd0) begin errors++; $display("FAIL rml_rr_ptr0 got=%0d exp=0", rr_grant); end
        @(negedge clk);
        rst = 1'b0;
        rr.i_req_valid = '0; rr.i_mem_ready = 1'b1;
        fx.i_mem_rsp_valid = 1'b1; fx.i_mem_rsp_data = 32'h0BAD_0BAD;
        #1;
        checks++; if (fx.o_rsp_valid !== 4'b0000) begin errors++; $display("FAIL rml_late_strobe got=%b exp=0000", fx.o_rsp_valid); end
        @(negedge clk);
        fx.i_mem_rsp_valid = 1'b0;
        #1;
        checks++; if (fx_orphan !== 1'b1) begin errors++; $display("FAIL rml_late_orphan got=%b exp=1", fx_orphan); end
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_lock();
        test_tracker_full();
        test_mem_not_ready_and_orphan();
        test_reset_mid_lock();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_multi_arbiter.md
Name: data_mem_multi_arbiter

Overview:
- N-port, parametrised successor to the fixed four-source data memory mux.
- Arbitrates valid/ready requests from N data-memory requesters onto one memory port. Candidate requesters: FP64 sequencer, AMO unit, EX path, a future DMA/debug master.
- Adds round-robin or fixed priority, lock hold for atomic read-modify-write sequences, and an in-order outstanding-read tracker that routes read responses back to the issuing port.
- Sits between the MA-stage request sources and the L0 cache / data memory.

Parameters:
- NUM_PORTS, 4, number of requesters; legal range 2..8; port 0 is highest priority in fixed mode.
- XLEN, riscv_pkg::XLEN, address and data width.
- ARB_MODE, mem_arb_pkg::ARB_FIXED, ARB_FIXED or ARB_ROUND_ROBIN.
- MAX_OUTSTANDING, 2, depth of the read-response routing FIFO; power of two, at least 1.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_req_valid  in  NUM_PORTS  per-port request valid.
- i_req_we  in  NUM_PORTS  1=write, 0=read.
- i_req_lock  in  NUM_PORTS  1=keep grant after this beat.
- i_req_addr  in  NUM_PORTS*XLEN  packed addresses, port p at [p*XLEN +: XLEN].
- i_req_wdata  in  NUM_PORTS*XLEN  packed write data.
- i_req_be  in  NUM_PORTS*4  packed byte enables; ignored for reads.
- o_req_ready  out  NUM_PORTS  beat accepted when valid&&ready.
- o_mem_addr  out  XLEN  granted address.
- o_mem_wr_data  out  XLEN  granted write data.
- o_mem_per_byte_wr_en  out  4  granted byte enables, gated by issue.
- o_mem_read_enable  out  1  read issued this cycle.
- i_mem_ready  in  1  memory can accept a beat this cycle.
- i_mem_rsp_valid  in  1  read data returned, in order.
- i_mem_rsp_data  in  XLEN  read data.
- o_rsp_valid  out  NUM_PORTS  one-hot response strobe.
- o_rsp_data  out  XLEN  broadcast response data.
- o_grant_idx  out  $clog2(NUM_PORTS)  current grant index, for debug/perf.
- o_locked  out  1  lock currently held.
- o_rsp_orphan  out  1  sticky: response arrived with the tracker empty.

Behaviour:
- Request path combinational (0-cycle latency); all state registered on i_clk.
- Grant select:
  - If lock is held: grant = lock_owner.
  - Else fixed mode: lowest-index valid port.
  - Else round-robin: first valid port at or after rr_ptr, with wrap-around modulo NUM_PORTS.
  - No valid port: o_grant_idx holds its last value.
- Eligibility:
  - A granted read is eligible only if the tracker is not full. Full is the registered count; a same-cycle pop does not free the slot. This keeps the rsp-to-ready path out.
  - Writes are always eligible.
- Issue = i_req_valid[g] && eligible && i_mem_ready.
- o_req_ready[g] = eligible && i_mem_ready. All other ports have ready=0.
- Memory-side outputs:
  - o_mem_addr and o_mem_wr_data always reflect the granted port.
  - o_mem_per_byte_wr_en = i_req_be[g] when issuing a write, else 0.
  - o_mem_read_enable = issue && !we.
- Round-robin pointer: on issue with no lock held, rr_ptr <= g+1 (wrapping). Pointer is unchanged while a lock is held.
- Lock FSM, states UNLOCKED / LOCKED:
  - UNLOCKED -> LOCKED on an issue with lock=1; capture lock_owner=g.
  - LOCKED -> UNLOCKED on an issue from lock_owner with lock=0.
  - While LOCKED, other ports are never granted.
  - Lock owner deasserting valid does not release the lock.
- Response tracker:
  - FIFO of port indices, MAX_OUTSTANDING deep, with wrapping read/write pointers and a count.
  - Push on a read issue. Pop on i_mem_rsp_valid when not empty.
  - o_rsp_valid = onehot(head) when rsp_valid && !empty; o_rsp_data = i_mem_rsp_data.
  - Simultaneous push and pop: count unchanged. Allowed when full only if the push is blocked (it is).
  - rsp_valid with an empty tracker: no strobe, and o_rsp_orphan is set until reset.
- Reset (async assert, sync deassert handled upstream):
  - rr_ptr=0, state=UNLOCKED, lock_owner=0, FIFO empty, o_rsp_orphan=0, o_grant_idx=0.
  - All combinational outputs evaluate to 0 under reset with no valids.
- Reset mid-lock or with outstanding reads: state is discarded. Late responses after reset flag o_rsp_orphan.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_mode_e {ARB_FIXED, ARB_ROUND_ROBIN}.
  - lock_state_e {UNLOCKED, LOCKED}.
  - Function port_idx_width(n).
  - Localparam BYTES_PER_WORD=4.
- One sub-module, mem_arb_rsp_tracker: the index FIFO with push/pop/full/empty/head and the orphan flag.

Test Plan:
- Fixed mode, NUM_PORTS=4, ports 1 and 3 valid reads, i_mem_ready=1 -> port 1 granted. Port 3 is granted the cycle after port 1 drops valid.
- Round-robin, all 4 ports continuously valid writes -> grant order 0,1,2,3,0. Exactly one o_req_ready high each cycle; be passes through.
- Port 2 issues a read with lock=1, then port 0 becomes valid -> port 0 stays ready=0 and o_locked=1. After port 2 issues a write with lock=0, port 0 is granted the next cycle.
- MAX_OUTSTANDING=2, reads from ports 0 and 1 with no response -> a third read is blocked. A response of 0xDEADBEEF strobes o_rsp_valid=4'b0001 with that data; next cycle the third read is accepted.
- i_mem_ready=0 with port 0 valid -> o_req_ready=0, wr_en=0, read_enable=0, FIFO count unchanged.
- Response with the tracker empty -> o_rsp_valid=0 and o_rsp_orphan=1 sticky. An i_rst pulse mid-lock -> o_locked=0, o_rsp_orphan=0, rr_ptr=0.
